trng_capture: RTL and testbench

- Receive-side counterpart of the ttrng board interface. Samples the forwarded TRNG clock and the 8-bit random number bus, both asynchronous to the local clock.
- Synchronizes and captures one byte per source clock period, then runs a repetition-count health test on each raw byte.
- Buffers accepted bytes in a first-word-fall-through FIFO with a valid/ready output, for use by a UART or host-side consumer.

---
 rtl/trng_capture.sv | 187 ++++++++++++++++++
 tb/tb_trng_capture.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_capture.sv
// rtl/trng_capture.sv - TRNG byte capture with synchronizer, repetition-count health test and FWFT FIFO
//
// Samples a forwarded TRNG clock and byte bus that are asynchronous to clk.
// One byte is taken per source period, on the synchronized falling edge.
// Each raw byte goes through a repetition-count test, then into a FIFO.
// Optional macro TRNG_CAPTURE_VN_EN inserts von Neumann debiasing between
// the health test and the FIFO.
//
// Ports:
//   clk, rst_n          local clock, asynchronous active-low reset
//   ena                 capture enable (the FIFO keeps draining when low)
//   clear               synchronous flush of FIFO, overflow, rct_fail, run counter
//   src_clk, src_data   asynchronous TRNG clock and 8-bit number bus
//   m_data/m_valid/m_ready   first-word-fall-through output stream
//   level               FIFO occupancy, 0..DEPTH
//   overflow            sticky, a byte was dropped on a full FIFO
//   rct_fail            sticky repetition-count failure

module trng_capture #(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int RCT_CUTOFF  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       clear,
    input  logic                       src_clk,
    input  logic [7:0]                 src_data,
    output logic [7:0]                 m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       rct_fail
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [7:0] CUTOFF = 8'(RCT_CUTOFF);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic                   clk_sync_d;
    logic [7:0]             data_sync [SYNC_STAGES];

    logic                   cap_valid;
    logic [7:0]             cap_byte;

    logic [7:0]             prev;
    logic                   prev_valid;
    logic [7:0]             run;

    logic [7:0]             mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [LW-1:0]          level_q;

    logic                   strobe;
    logic [7:0]             run_next;
    logic                   trip;
    logic                   raw_ok;
    logic                   push_req;
    logic [7:0]             push_byte;
    logic                   full;
    logic                   pop;
    logic                   push;
    logic                   drop;

    // Falling edge of the synchronized source clock lands mid-period, where
    // src_data has been stable for half a source cycle.
    assign strobe = clk_sync_d & ~clk_sync[SYNC_STAGES-1] & ena;

    assign run_next = (prev_valid && cap_byte == prev)
                    ? ((run == 8'hFF) ? run : run + 8'd1)
                    : 8'd1;
    assign trip     = cap_valid && (run_next >= CUTOFF);
    assign raw_ok   = cap_valid && !rct_fail && !trip;

`ifdef TRNG_CAPTURE_VN_EN
    logic [7:0] vn_acc;
    logic [3:0] vn_cnt;
    logic [7:0] vn_acc_n;
    logic [3:0] vn_cnt_n;

    // A raw byte yields at most 4 bits, so at most one byte completes per capture.
    always_comb begin
        vn_acc_n  = vn_acc;
        vn_cnt_n  = vn_cnt;
        push_req  = 1'b0;
        push_byte = vn_acc;
        if (raw_ok) begin
            for (int i = 3; i >= 0; i--) begin
                if (cap_byte[2*i+1] != cap_byte[2*i]) begin
                    vn_acc_n = {vn_acc_n[6:0], cap_byte[2*i+1]};
                    vn_cnt_n = vn_cnt_n + 4'd1;
                    if (vn_cnt_n == 4'd8) begin
                        push_req  = 1'b1;
                        push_byte = vn_acc_n;
                        vn_cnt_n  = 4'd0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vn_acc <= 8'd0;
            vn_cnt <= 4'd0;
        end else if (clear) begin
            vn_acc <= 8'd0;
            vn_cnt <= 4'd0;
        end else begin
            vn_acc <= vn_acc_n;
            vn_cnt <= vn_cnt_n;
        end
    end
`else
    assign push_req  = raw_ok;
    assign push_byte = cap_byte;
`endif

    assign full = (level_q == LW'(DEPTH));
    assign pop  = (level_q != '0) && m_ready;
    assign push = push_req && (!full || pop);
    assign drop = push_req && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync   <= '0;
            clk_sync_d <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= 8'd0;
            cap_valid  <= 1'b0;
            cap_byte   <= 8'd0;
            prev       <= 8'd0;
            prev_valid <= 1'b0;
            run        <= 8'd0;
            rct_fail   <= 1'b0;
            overflow   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], src_clk};
            clk_sync_d <= clk_sync[SYNC_STAGES-1];
            data_sync[0] <= src_data;
            for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];

            if (clear) begin
                cap_valid  <= 1'b0;
                prev_valid <= 1'b0;
                run        <= 8'd0;
                rct_fail   <= 1'b0;
                overflow   <= 1'b0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                level_q    <= '0;
            end else begin
                cap_valid <= strobe;
                if (strobe) cap_byte <= data_sync[SYNC_STAGES-1];

                // The health test keeps tracking runs even after a failure.
                if (cap_valid) begin
                    run        <= run_next;
                    prev       <= cap_byte;
                    prev_valid <= 1'b1;
                    if (trip) rct_fail <= 1'b1;
                end

                if (push) begin
                    mem[wr_ptr] <= push_byte;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      level_q <= level_q + 1'b1;
                else if (pop && !push) level_q <= level_q - 1'b1;
                if (drop) overflow <= 1'b1;
            end
        end
    end

    assign m_data  = mem[rd_ptr];
    assign m_valid = (level_q != '0);
    assign level   = level_q;

endmodule

// File: tb/tb_trng_capture.sv
// tb/tb_trng_capture.sv - self-checking bench for trng_capture

module tb_trng_capture;

    localparam int DEPTH = 8;
    localparam int SYNC  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       clear;
    logic       src_clk;
    logic [7:0] src_data;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [3:0] level;
    logic       overflow;
    logic       rct_fail;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q [$];

    typedef struct {
        logic [7:0] data;
        bit         exp_push;
        bit         exp_fail;
    } vec_t;

    trng_capture #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .RCT_CUTOFF(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
        .src_clk(src_clk), .src_data(src_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .level(level), .overflow(overflow), .rct_fail(rct_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every accepted output byte is compared with the queue head.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none", m_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h", m_data, e);
                end
            end
        end
    end

    // One source period: 4 clk high, 4 clk low. Entry and exit at posedge+1.
    task automatic feed(input logic [7:0] b);
        src_data = b;
        src_clk  = 1'b1;
        repeat (4) @(posedge clk);
        #1 src_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Same as feed, but measures the falling-edge to m_valid latency.
    task automatic feed_timed(input logic [7:0] b);
        bit got;
        src_data = b;
        src_clk  = 1'b1;
        repeat (4) @(posedge clk);
        #1 src_clk = 1'b0;
        got = 0;
        for (int i = 0; i < SYNC + 3; i++) begin
            @(negedge clk);
            if (m_valid) got = 1;
        end
        check("latency", 32'(got), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain(input string name);
        m_ready = 1'b1;
        repeat (DEPTH + 4) @(posedge clk);
        #1 m_ready = 1'b0;
        check(name, 32'(exp_q.size()), 32'd0);
        check({name, "_level"}, 32'(level), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs [9];
        logic [7:0] b;

        rst_n = 1'b0; ena = 1'b1; clear = 1'b0;
        src_clk = 1'b0; src_data = 8'd0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid",  32'(m_valid),  32'd0);
        check("rst_level",    32'(level),    32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_rct_fail", 32'(rct_fail), 32'd0);
        check("rst_m_data",   32'(m_data),   32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

`ifdef TRNG_CAPTURE_VN_EN
        feed(8'h69);
        check("vn_level_first", 32'(level), 32'd0);
        exp_q.push_back(8'h69);
        feed(8'h96);
        check("vn_level_second", 32'(level), 32'd1);
        ena = 1'b0;
        feed(8'h69);
        feed(8'h96);
        check("vn_ena_off_level", 32'(level), 32'd1);
        ena = 1'b1;
        drain("vn_drain");
`else
        // Raw path, streaming consumer
        m_ready = 1'b1;
        exp_q.push_back(8'h3C); feed_timed(8'h3C);
        exp_q.push_back(8'hA5); feed_timed(8'hA5);
        exp_q.push_back(8'h01); feed_timed(8'h01);
        m_ready = 1'b0;
        check("raw_q_empty", 32'(exp_q.size()), 32'd0);
        check("raw_overflow", 32'(overflow), 32'd0);

        // Capture disabled
        ena = 1'b0;
        feed(8'h11);
        feed(8'h22);
        check("ena_off_level", 32'(level), 32'd0);
        ena = 1'b1;

        // Overflow: 10 distinct bytes into 8 entries
        pulse_clear();
        for (int i = 0; i < 10; i++) begin
            b = 8'(8'h10 + i * 8'h13);
            if (i < DEPTH) exp_q.push_back(b);
            feed(b);
        end
        check("ovf_level", 32'(level), 32'd8);
        check("ovf_flag",  32'(overflow), 32'd1);
        drain("ovf_drain");

        // Full FIFO with a pop on the push cycle
        pulse_clear();
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'(8'h40 + i);
            exp_q.push_back(b);
            feed(b);
        end
        check("full_level", 32'(level), 32'd8);
        exp_q.push_back(8'hC7);
        src_data = 8'hC7;
        src_clk  = 1'b1;
        repeat (4) @(posedge clk);
        #1 src_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1 m_ready = 1'b1;
        @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("full_pop_level",    32'(level),    32'd8);
        check("full_pop_overflow", 32'(overflow), 32'd0);
        drain("full_pop_drain");

        // Health test, table driven
        pulse_clear();
        vecs[0] = '{8'h55, 1, 0};
        vecs[1] = '{8'h55, 1, 0};
        vecs[2] = '{8'h55, 1, 0};
        vecs[3] = '{8'h12, 1, 0};
        vecs[4] = '{8'h77, 1, 0};
        vecs[5] = '{8'h77, 1, 0};
        vecs[6] = '{8'h77, 1, 0};
        vecs[7] = '{8'h77, 0, 1};
        vecs[8] = '{8'h9A, 0, 1};
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].exp_push) exp_q.push_back(vecs[i].data);
            feed(vecs[i].data);
            check($sformatf("rct_fail_v%0d", i), 32'(rct_fail), 32'(vecs[i].exp_fail));
        end
        check("rct_level", 32'(level), 32'd7);
        pulse_clear();
        check("clr_level",    32'(level),    32'd0);
        check("clr_rct_fail", 32'(rct_fail), 32'd0);
        exp_q.push_back(8'h77);
        feed(8'h77);
        check("resume_level", 32'(level), 32'd1);
        drain("rct_drain");

        // Asynchronous reset with data buffered
        for (int i = 0; i < 5; i++) begin
            b = 8'(8'hA0 + i);
            feed(b);
        end
        check("pre_rst_level", 32'(level), 32'd5);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_m_valid", 32'(m_valid), 32'd0);
        check("async_rst_level",   32'(level),   32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'hA4);
            feed(8'hA4);
        end
        check("post_rst_rct_fail", 32'(rct_fail), 32'd0);
        check("post_rst_level",    32'(level),    32'd3);
        drain("post_rst_drain");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
